pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stall thermometer, exception flush FSM.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        wdt_timeout
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      REFILL = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [5:0]  req_stall;
   logic        accept;

   always_comb begin
      req_stall = 6'b000000;
      priority case (1'b1)
         stallreq_mem: req_stall = 6'b011111;
         stallreq_ex:  req_stall = 6'b001111;
         stallreq_id:  req_stall = 6'b000111;
         stallreq_if:  req_stall = 6'b000011;
         default:      req_stall = 6'b000000;
      endcase
   end

   // Reset gates stall combinationally so requests cannot leak through.
   assign stall  = (!rst || state_q == FLUSH) ? 6'b000000 : req_stall;
   assign accept = (state_q == RUN) && (excepttype != 32'd0) && !stallreq_mem;

   always_comb begin
      state_d  = state_q;
      new_pc_d = new_pc_q;
      flush_d  = 1'b0;
      unique case (state_q)
         RUN: begin
            if (accept) begin
               state_d = FLUSH;
               flush_d = 1'b1;
               if (excepttype == 32'h0000_0001)
                  new_pc_d = 32'h0000_0020;
               else if (excepttype == 32'h0000_000e)
                  new_pc_d = cp0_epc;
               else
                  new_pc_d = 32'h0000_0040;
            end
         end
         FLUSH:   state_d = REFILL;
         REFILL:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         flush_q  <= 1'b0;
         new_pc_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end

   assign flush  = flush_q;
   assign new_pc = new_pc_q;

`ifdef STALL_WDT_EN
   logic [7:0] wdt_cnt_q;
   logic       wdt_q;
   logic       stalled;

   assign stalled = |stall;

   // Pulse lands in the cycle the counter first reads 255, then saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdt_cnt_q <= 8'd0;
         wdt_q     <= 1'b0;
      end else if (!stalled) begin
         wdt_cnt_q <= 8'd0;
         wdt_q     <= 1'b0;
      end else begin
         if (wdt_cnt_q != 8'd255)
            wdt_cnt_q <= wdt_cnt_q + 8'd1;
         wdt_q <= (wdt_cnt_q == 8'd254);
      end
   end

   assign wdt_timeout = wdt_q;
`else
   assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus redirect/reset/watchdog sequences.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] excepttype, cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        wdt_timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excepttype   (excepttype),
      .cp0_epc      (cp0_epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .wdt_timeout  (wdt_timeout)
   );

   typedef struct {
      logic [3:0] req;
      logic [5:0] exp_stall;
   } vec_t;

   vec_t tbl[10];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] r);
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
   endtask

   initial begin
      vec_t e;
      int pulses;
      int pulse_at;

      tbl[0] = '{4'b0000, 6'b000000};
      tbl[1] = '{4'b0001, 6'b000011};
      tbl[2] = '{4'b0010, 6'b000111};
      tbl[3] = '{4'b0100, 6'b001111};
      tbl[4] = '{4'b1000, 6'b011111};
      tbl[5] = '{4'b0111, 6'b001111};
      tbl[6] = '{4'b1111, 6'b011111};
      tbl[7] = '{4'b0011, 6'b000111};
      tbl[8] = '{4'b1001, 6'b011111};
      tbl[9] = '{4'b0110, 6'b001111};

      rst = 1'b0;
      set_req(4'b1111);
      excepttype = 32'h8;
      cp0_epc    = 32'h0;
      #3;
      chk("rst_stall", {26'd0, stall}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_new_pc", new_pc, 32'd0);
      chk("rst_wdt", {31'd0, wdt_timeout}, 32'd0);
      cyc();
      cyc();
      #3;
      chk("rst_hold_stall", {26'd0, stall}, 32'd0);
      chk("rst_hold_flush", {31'd0, flush}, 32'd0);

      cyc();
      set_req(4'b0000);
      excepttype = 32'h0;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cyc();
         set_req(tbl[i].req);
         sb.push_back(tbl[i]);
         #3;
         e = sb.pop_front();
         chk($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, e.exp_stall});
         chk($sformatf("vec%0d_flush", i), {31'd0, flush}, 32'd0);
      end
      cyc();
      set_req(4'b0000);

      cyc();
      excepttype = 32'h8;
      #3;
      chk("exc8_accept_flush", {31'd0, flush}, 32'd0);
      cyc();
      excepttype = 32'h0;
      stallreq_ex = 1'b1;
      #3;
      chk("exc8_flush", {31'd0, flush}, 32'd1);
      chk("exc8_new_pc", new_pc, 32'h40);
      chk("exc8_flush_stall", {26'd0, stall}, 32'd0);
      cyc();
      #3;
      chk("exc8_refill_flush", {31'd0, flush}, 32'd0);
      chk("exc8_refill_stall", {26'd0, stall}, 32'h0f);
      chk("exc8_hold_pc", new_pc, 32'h40);
      cyc();
      stallreq_ex = 1'b0;
      #3;
      chk("exc8_run_flush", {31'd0, flush}, 32'd0);

      for (int k = 0; k < 3; k++) begin
         cyc();
         excepttype   = 32'he;
         cp0_epc      = 32'h8000_1234;
         stallreq_mem = 1'b1;
         #3;
         chk($sformatf("eret_memstall%0d", k), {26'd0, stall}, 32'h1f);
         chk($sformatf("eret_noflush%0d", k), {31'd0, flush}, 32'd0);
      end
      cyc();
      stallreq_mem = 1'b0;
      #3;
      chk("eret_accept_flush", {31'd0, flush}, 32'd0);
      cyc();
      excepttype = 32'h0;
      cp0_epc    = 32'hdead_beef;
      #3;
      chk("eret_flush", {31'd0, flush}, 32'd1);
      chk("eret_new_pc", new_pc, 32'h8000_1234);
      cyc();
      #3;
      chk("eret_refill", {31'd0, flush}, 32'd0);
      cyc();
      #3;
      chk("eret_run", {31'd0, flush}, 32'd0);

      cyc();
      excepttype = 32'h1;
      #3;
      chk("int_accept", {31'd0, flush}, 32'd0);
      cyc();
      #3;
      chk("int_flush", {31'd0, flush}, 32'd1);
      chk("int_new_pc", new_pc, 32'h20);
      cyc();
      #3;
      chk("int_refill_masked", {31'd0, flush}, 32'd0);
      cyc();
      #3;
      chk("int_run_reaccept", {31'd0, flush}, 32'd0);
      cyc();
      #3;
      chk("int_second_flush", {31'd0, flush}, 32'd1);
      cyc();
      #3;
      chk("int_refill2", {31'd0, flush}, 32'd0);
      cyc();
      excepttype = 32'h0;
      #3;
      chk("int_run_clear", {31'd0, flush}, 32'd0);
      cyc();
      #3;
      chk("int_no_third", {31'd0, flush}, 32'd0);

      cyc();
      excepttype = 32'h8;
      cyc();
      excepttype  = 32'h0;
      stallreq_ex = 1'b1;
      #2;
      chk("rstmid_flush_before", {31'd0, flush}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rstmid_flush", {31'd0, flush}, 32'd0);
      chk("rstmid_stall", {26'd0, stall}, 32'd0);
      chk("rstmid_new_pc", new_pc, 32'd0);
      cyc();
      #3;
      chk("rstmid_hold", {31'd0, flush}, 32'd0);
      cyc();
      rst = 1'b1;
      #3;
      chk("rstrel_flush", {31'd0, flush}, 32'd0);
      chk("rstrel_run_stall", {26'd0, stall}, 32'h0f);
      cyc();
      #3;
      chk("rstrel_flush2", {31'd0, flush}, 32'd0);
      cyc();
      stallreq_ex = 1'b0;
      #3;

      pulses   = 0;
      pulse_at = 0;
      for (int n = 1; n <= 300; n++) begin
         cyc();
         stallreq_ex = 1'b1;
         #3;
         if (wdt_timeout === 1'b1) begin
            pulses++;
            pulse_at = n;
         end
      end
      cyc();
      stallreq_ex = 1'b0;
      #3;
      chk("wdt_idle", {31'd0, wdt_timeout}, 32'd0);
`ifdef STALL_WDT_EN
      chk("wdt_pulses", pulses, 32'd1);
      chk("wdt_pulse_cycle", pulse_at, 32'd256);
`else
      chk("wdt_pulses", pulses, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
